// File: rtl/ext_trig_xcvr.sv
// ext_trig_xcvr: multi-channel external trigger transceiver.
//
// Each channel drives the shared external trigger pad from the MAROC pixel
// trigger and receives triggers from the same pad. The pad's IOBUF primitive
// is instantiated by the top level, which wires ext_trig_o/_t/_i to it.
//
// TX: a rising edge of pixel_trig (with TX enabled) drives the pad low-Z
//     (ext_trig_t = 0) for STRETCH cycles. A new edge during the drive reloads
//     the stretch counter. When the drive ends, a HOLDOFF window starts.
// RX: the pad input is synchronised (2 FFs) and glitch filtered. A filtered
//     rising level is reported as a one-cycle ext_trig_rx pulse and counted,
//     unless RX is disabled, the channel is driving, or holdoff is running.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   mode         per channel {rx_en, tx_en} in bits [2c+1:2c]
//   pixel_trig   per-channel MAROC trigger, synchronous to clk
//   cnt_clr      synchronous clear of all rx_count fields
//   ext_trig_i   pad input from IOBUF O (asynchronous)
//   ext_trig_o   pad data to IOBUF I (always drive high)
//   ext_trig_t   pad tristate to IOBUF T (1 = hi-Z, 0 = drive)
//   ext_trig_rx  one-cycle pulse per accepted received trigger
//   tx_busy      high while the channel drives the pad
//   rx_count     saturating per-channel RX count, channel c at [(c+1)*CNT_W-1:c*CNT_W]

module ext_trig_xcvr #(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned STRETCH = 8,
    parameter int unsigned HOLDOFF = 4,
    parameter int unsigned FILT    = 3,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2*N_CH-1:0]       mode,
    input  logic [N_CH-1:0]         pixel_trig,
    input  logic                    cnt_clr,
    input  logic [N_CH-1:0]         ext_trig_i,
    output logic [N_CH-1:0]         ext_trig_o,
    output logic [N_CH-1:0]         ext_trig_t,
    output logic [N_CH-1:0]         ext_trig_rx,
    output logic [N_CH-1:0]         tx_busy,
    output logic [N_CH*CNT_W-1:0]   rx_count
);

    localparam int unsigned StretchW = $clog2(STRETCH + 1);
    localparam int unsigned HoldW    = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam int unsigned FiltW    = $clog2(FILT + 1);

    localparam logic [StretchW-1:0] StretchVal = StretchW'(STRETCH);
    localparam logic [HoldW-1:0]    HoldVal    = HoldW'(HOLDOFF);
    localparam logic [FiltW-1:0]    FiltVal    = FiltW'(FILT);
    localparam logic [CNT_W-1:0]    CntMax     = '1;

    // The pad is only ever driven high; the tristate control does the work.
    assign ext_trig_o = '1;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic                tx_en;
        logic                rx_en;
        logic                tx_edge;

        logic                pix_q;
        logic [StretchW-1:0] drv_cnt_q, drv_cnt_d;
        logic [HoldW-1:0]    hold_cnt_q, hold_cnt_d;
        logic                t_q, t_d;
        logic                busy_q, busy_d;

        logic                sync1_q, sync2_q;
        logic                filt_q, filt_d;
        logic [FiltW-1:0]    fcnt_q, fcnt_d;
        logic                rx_q, rx_d;
        logic [CNT_W-1:0]    cnt_q, cnt_d;

        assign tx_en   = mode[2*c];
        assign rx_en   = mode[2*c+1];
        assign tx_edge = pixel_trig[c] & ~pix_q;

        // TX stretch and holdoff counters.
        always_comb begin
            drv_cnt_d  = drv_cnt_q;
            hold_cnt_d = hold_cnt_q;

            if (drv_cnt_q != '0) begin
                drv_cnt_d = drv_cnt_q - StretchW'(1);
            end
            if (!tx_en) begin
                // Disabling TX cuts an active drive short at the next edge.
                drv_cnt_d = '0;
            end else if (tx_edge) begin
                drv_cnt_d = StretchVal;
            end

            if (hold_cnt_q != '0) begin
                hold_cnt_d = hold_cnt_q - HoldW'(1);
            end
            // Holdoff starts whenever a drive finishes, however it finished.
            if ((drv_cnt_q != '0) && (drv_cnt_d == '0)) begin
                hold_cnt_d = HoldVal;
            end

            t_d    = (drv_cnt_d == '0);
            busy_d = (drv_cnt_d != '0);
        end

        // RX glitch filter, accept qualification and saturating counter.
        // The level flips on the edge after the run counter has reached FILT,
        // provided the synchronised sample still disagrees with the level.
        always_comb begin
            filt_d = filt_q;
            fcnt_d = '0;
            if (sync2_q != filt_q) begin
                if (fcnt_q == FiltVal) begin
                    filt_d = sync2_q;
                end else begin
                    fcnt_d = fcnt_q + FiltW'(1);
                end
            end

            // A rise seen while suppressed is dropped for good: the filter
            // level is already high when suppression lifts.
            rx_d = ~filt_q & filt_d & rx_en & ~busy_q & (hold_cnt_q == '0);

            cnt_d = cnt_q;
            if (cnt_clr) begin
                cnt_d = '0;
            end else if (rx_d && (cnt_q != CntMax)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pix_q      <= 1'b0;
                drv_cnt_q  <= '0;
                hold_cnt_q <= '0;
                t_q        <= 1'b1;
                busy_q     <= 1'b0;
                sync1_q    <= 1'b0;
                sync2_q    <= 1'b0;
                filt_q     <= 1'b0;
                fcnt_q     <= '0;
                rx_q       <= 1'b0;
                cnt_q      <= '0;
            end else begin
                pix_q      <= pixel_trig[c];
                drv_cnt_q  <= drv_cnt_d;
                hold_cnt_q <= hold_cnt_d;
                t_q        <= t_d;
                busy_q     <= busy_d;
                sync1_q    <= ext_trig_i[c];
                sync2_q    <= sync1_q;
                filt_q     <= filt_d;
                fcnt_q     <= fcnt_d;
                rx_q       <= rx_d;
                cnt_q      <= cnt_d;
            end
        end

        assign ext_trig_t[c]                = t_q;
        assign tx_busy[c]                   = busy_q;
        assign ext_trig_rx[c]               = rx_q;
        assign rx_count[c*CNT_W +: CNT_W]   = cnt_q;
    end

endmodule

// File: tb/tb_ext_trig_xcvr.sv
// Directed bench for ext_trig_xcvr: TX stretch/retrigger, RX filter/accept,
// echo suppression and holdoff, counter saturation/clear, reset mid-drive.
// A second instance with CNT_W = 2 shares all inputs to show saturation.

module tb_ext_trig_xcvr;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  mode;
    logic [3:0]  pixel_trig;
    logic        cnt_clr;
    logic [3:0]  ext_trig_i;
    logic [3:0]  ext_drv;
    logic        loop_en;

    logic [3:0]  ext_trig_o, ext_trig_t, ext_trig_rx, tx_busy;
    logic [63:0] rx_count;
    logic [3:0]  o2, t2, rx2, busy2;
    logic [7:0]  cnt2;

    int total = 0;
    int bad   = 0;
    int lows, first, last, pulses, at;

    always #5 clk = ~clk;

    // Optional loopback: the pad reads high while this channel drives it.
    assign ext_trig_i = ({4{loop_en}} & ~ext_trig_t) | ext_drv;

    ext_trig_xcvr dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode        (mode),
        .pixel_trig  (pixel_trig),
        .cnt_clr     (cnt_clr),
        .ext_trig_i  (ext_trig_i),
        .ext_trig_o  (ext_trig_o),
        .ext_trig_t  (ext_trig_t),
        .ext_trig_rx (ext_trig_rx),
        .tx_busy     (tx_busy),
        .rx_count    (rx_count)
    );

    ext_trig_xcvr #(.CNT_W(2)) dut2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .mode        (mode),
        .pixel_trig  (pixel_trig),
        .cnt_clr     (cnt_clr),
        .ext_trig_i  (ext_trig_i),
        .ext_trig_o  (o2),
        .ext_trig_t  (t2),
        .ext_trig_rx (rx2),
        .tx_busy     (busy2),
        .rx_count    (cnt2)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        mode       = '0;
        pixel_trig = '0;
        cnt_clr    = 1'b0;
        ext_drv    = '0;
        loop_en    = 1'b0;
        rst_n      = 1'b1;

        // Reset values
        #2 rst_n = 1'b0;
        #1;
        chk("rst_t", ext_trig_t, 64'hF);
        chk("rst_o", ext_trig_o, 64'hF);
        chk("rst_busy", tx_busy, 64'h0);
        chk("rst_rx", ext_trig_rx, 64'h0);
        chk("rst_cnt", rx_count, 64'h0);
        chk("rst_cnt2", cnt2, 64'h0);
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Single pulse: 8-cycle drive starting the cycle after the edge
        mode = 8'h01;
        pixel_trig = 4'h1;
        step();
        pixel_trig = 4'h0;
        for (int i = 0; i < 8; i++) begin
            chk("tx_drive_t", ext_trig_t, 64'hE);
            chk("tx_drive_busy", tx_busy, 64'h1);
            step();
        end
        chk("tx_end_t", ext_trig_t, 64'hF);
        chk("tx_end_busy", tx_busy, 64'h0);
        repeat (8) step();

        // Retrigger 5 cycles in: 13 contiguous drive cycles
        lows = 0; first = -1; last = -1;
        for (int i = 0; i < 24; i++) begin
            pixel_trig[0] = (i == 0 || i == 5);
            step();
            if (ext_trig_t[0] == 1'b0) begin
                lows++;
                if (first < 0) first = i;
                last = i;
            end
        end
        chk("retrig_len", lows, 13);
        chk("retrig_start", first, 0);
        chk("retrig_contig", last - first + 1, 13);
        pixel_trig = 4'h0;
        repeat (6) step();

        // Held-high pixel_trig: single 8-cycle drive
        lows = 0;
        for (int i = 0; i < 30; i++) begin
            pixel_trig[0] = (i < 20);
            step();
            if (ext_trig_t[0] == 1'b0) lows++;
        end
        chk("held_len", lows, 8);
        pixel_trig = 4'h0;
        repeat (6) step();

        // TX disabled mid-drive: drive stops on the next edge
        pixel_trig = 4'h1;
        step();
        pixel_trig = 4'h0;
        step();
        step();
        chk("dis_pre_t", ext_trig_t, 64'hE);
        mode = 8'h00;
        step();
        chk("dis_post_t", ext_trig_t, 64'hF);
        chk("dis_post_busy", tx_busy, 64'h0);
        repeat (8) step();

        // RX glitch of 2 cycles is filtered out
        mode = 8'h02;
        pulses = 0;
        for (int i = 0; i < 15; i++) begin
            ext_drv[0] = (i < 2);
            step();
            if (ext_trig_rx[0]) pulses++;
        end
        chk("glitch_rx", pulses, 0);
        chk("glitch_cnt", rx_count, 64'h0);

        // RX accept: 10-cycle pulse, rx at edge 5 after first sample
        pulses = 0; at = -1;
        for (int i = 0; i < 20; i++) begin
            ext_drv[0] = (i < 10);
            step();
            if (ext_trig_rx[0]) begin
                pulses++;
                at = i;
            end
        end
        chk("acc_pulses", pulses, 1);
        chk("acc_edge", at, 5);
        chk("acc_cnt", rx_count, 64'h1);
        chk("acc_cnt2", cnt2, 64'h1);

        // Echo suppression with loopback
        mode = 8'h03;
        loop_en = 1'b1;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            pixel_trig[0] = (i == 0);
            step();
            if (ext_trig_rx[0]) pulses++;
        end
        chk("echo_rx", pulses, 0);

        // External pulse 2 cycles after drive end: merged with echo, not counted
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            pixel_trig[0] = (i == 0);
            ext_drv[0] = (i >= 10 && i < 20);
            step();
            if (ext_trig_rx[0]) pulses++;
        end
        chk("late2_rx", pulses, 0);
        repeat (5) step();

        // External pulse 6 cycles after drive end: counted
        pulses = 0; at = -1;
        for (int i = 0; i < 30; i++) begin
            pixel_trig[0] = (i == 0);
            ext_drv[0] = (i >= 14 && i < 24);
            step();
            if (ext_trig_rx[0]) begin
                pulses++;
                at = i;
            end
        end
        chk("late6_pulses", pulses, 1);
        chk("late6_edge", at, 19);
        chk("late6_cnt", rx_count, 64'h2);
        repeat (5) step();

        // Filtered rise during holdoff is discarded (no loopback)
        loop_en = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            pixel_trig[0] = (i == 0);
            ext_drv[0] = (i >= 6 && i < 16);
            step();
            if (ext_trig_rx[0]) pulses++;
        end
        chk("holdoff_rx", pulses, 0);
        chk("holdoff_cnt", rx_count, 64'h2);
        pixel_trig = 4'h0;

        // Saturation: CNT_W = 2 instance sticks at 3
        mode = 8'h02;
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < 20; i++) begin
                ext_drv[0] = (i < 10);
                step();
            end
            chk("sat_cnt", rx_count, 64'(3 + p));
            chk("sat_cnt2", cnt2, 64'h3);
        end

        // cnt_clr coincident with an accepted pulse wins
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            ext_drv[0] = (i < 10);
            cnt_clr = (i == 5);
            step();
            if (ext_trig_rx[0]) pulses++;
        end
        cnt_clr = 1'b0;
        chk("clr_pulses", pulses, 1);
        chk("clr_cnt", rx_count, 64'h0);
        chk("clr_cnt2", cnt2, 64'h0);

        // Reset mid-drive: pad released immediately, drive abandoned
        mode = 8'h01;
        pixel_trig = 4'h1;
        step();
        pixel_trig = 4'h0;
        repeat (3) step();
        chk("rstmid_pre_t", ext_trig_t, 64'hE);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_t", ext_trig_t, 64'hF);
        chk("rstmid_busy", tx_busy, 64'h0);
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("rstmid_after_t", ext_trig_t, 64'hF);
        chk("rstmid_after_busy", tx_busy, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
